stream_index_permuter: RTL and testbench

- Streaming, double-buffered reorder unit for the non-power-of-two NTT datapath. Replaces the flat, fully combinational list permutation.
- Accepts one SIZE-element frame, one element per cycle over valid/ready, and emits it in a per-frame selected order: natural, offset bit-reversed, or constant-stride (mod SIZE).
- Two SIZE-deep banks give full overlap: one frame is written while the previous frame is read.

---
 rtl/stream_index_permuter.sv | 186 ++++++++++++++++++
 tb/tb_stream_index_permuter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_index_permuter.sv
// Double-buffered streaming reorder unit: writes a frame in natural order,
// reads it back natural, offset bit-reversed or constant-stride.
`timescale 1ns/1ps
module stream_index_permuter #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 257,
    parameter int BR_BITS = 8,
    parameter int ADDR_W  = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_mode,
    input  logic [ADDR_W-1:0] in_step,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              cfg_err
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(SIZE - 1);
    localparam logic [ADDR_W:0]   SIZE_X = (ADDR_W+1)'(SIZE);

    logic [WIDTH-1:0]  r_mem0 [SIZE];
    logic [WIDTH-1:0]  r_mem1 [SIZE];
    logic [1:0]        r_full;
    logic              r_wptr;
    logic              r_rptr;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_rcnt;
    logic [ADDR_W-1:0] r_raddr;
    logic [1:0]        r_mode [2];
    logic [ADDR_W-1:0] r_step [2];
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [WIDTH-1:0]  r_rdata;
    logic [WIDTH-1:0]  r_q_data [2];
    logic [1:0]        r_q_last;
    logic [1:0]        r_q_cnt;
    logic              r_err;

    logic              w_wr;
    logic              w_pop;
    logic              w_rd;
    logic [2:0]        w_occ;
    logic              w_bad;
    logic [1:0]        w_mode_eff;
    logic [ADDR_W-1:0] w_step_eff;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_next;

    function automatic logic [BR_BITS-1:0] f_bitrev(input logic [BR_BITS-1:0] v);
        for (int i = 0; i < BR_BITS; i++) f_bitrev[i] = v[BR_BITS-1-i];
    endfunction

    assign in_ready  = !r_full[r_wptr];
    assign out_valid = (r_q_cnt != 2'd0);
    assign out_data  = r_q_data[0];
    assign out_last  = out_valid && r_q_last[0];
    assign cfg_err   = r_err;

    assign w_wr  = in_valid && in_ready;
    assign w_pop = out_valid && out_ready;
    // Issue only if the skid buffer can still hold the in-flight read.
    assign w_occ = {1'b0, r_q_cnt} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_rd  = r_full[r_rptr] && (w_occ < 3'd2);

    always_comb begin
        w_mode_eff = in_mode;
        w_step_eff = in_step;
        w_bad      = 1'b0;
        if (in_mode == 2'd3) begin
            w_mode_eff = 2'd0;
            w_bad      = 1'b1;
        end else if (in_mode == 2'd2 &&
                     (in_step == '0 || {1'b0, in_step} >= SIZE_X)) begin
            w_step_eff = ADDR_W'(1);
            w_bad      = 1'b1;
        end
    end

    assign w_sum = {1'b0, r_raddr} + {1'b0, r_step[r_rptr]};

    always_comb begin
        w_next = r_rcnt + ADDR_W'(1);
        case (r_mode[r_rptr])
            2'd1: w_next = ADDR_W'(f_bitrev(r_rcnt[BR_BITS-1:0])) + ADDR_W'(1);
            2'd2: w_next = (w_sum >= SIZE_X) ? ADDR_W'(w_sum - SIZE_X)
                                             : w_sum[ADDR_W-1:0];
            default: w_next = r_rcnt + ADDR_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (r_wptr) r_mem1[r_wcnt] <= in_data;
            else        r_mem0[r_wcnt] <= in_data;
        end
        if (w_rd) r_rdata <= r_rptr ? r_mem1[r_raddr] : r_mem0[r_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_raddr     <= '0;
            r_mode[0]   <= '0;
            r_mode[1]   <= '0;
            r_step[0]   <= '0;
            r_step[1]   <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_last    <= '0;
            r_q_cnt     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr) begin
                if (r_wcnt == '0) begin
                    r_mode[r_wptr] <= w_mode_eff;
                    r_step[r_wptr] <= w_step_eff;
                    if (w_bad) r_err <= 1'b1;
                end
                if (r_wcnt == LAST) begin
                    r_full[r_wptr] <= 1'b1;
                    r_wcnt         <= '0;
                    r_wptr         <= ~r_wptr;
                end else begin
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                end
            end

            r_rd_vld <= w_rd;
            if (w_rd) begin
                r_rd_last <= (r_rcnt == LAST);
                if (r_rcnt == LAST) begin
                    r_full[r_rptr] <= 1'b0;
                    r_rcnt         <= '0;
                    r_raddr        <= '0;
                    r_rptr         <= ~r_rptr;
                end else begin
                    r_rcnt  <= r_rcnt + ADDR_W'(1);
                    r_raddr <= w_next;
                end
            end

            case ({r_rd_vld, w_pop})
                2'b10: begin
                    if (r_q_cnt == 2'd0) begin
                        r_q_data[0] <= r_rdata;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[1] <= r_rdata;
                        r_q_last[1] <= r_rd_last;
                    end
                    r_q_cnt <= r_q_cnt + 2'd1;
                end
                2'b01: begin
                    r_q_data[0] <= r_q_data[1];
                    r_q_last[0] <= r_q_last[1];
                    r_q_cnt     <= r_q_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_q_cnt == 2'd1) begin
                        r_q_data[0] <= r_rdata;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_last[0] <= r_q_last[1];
                        r_q_data[1] <= r_rdata;
                        r_q_last[1] <= r_rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_index_permuter.sv
// Directed bench for stream_index_permuter: ordering modes, stalls,
// config errors, latency/throughput and mid-frame reset.
`timescale 1ns/1ps
module tb_stream_index_permuter;

    localparam int SIZE = 257;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic [8:0]  in_step;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;
    int f_mode [4];
    int f_step [4];
    int f_base [4];
    int cap [SIZE];
    int seen [SIZE];
    int first_val, last_acc, last_out, stall_seen;

    stream_index_permuter #(.WIDTH(32), .SIZE(SIZE), .BR_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_step(in_step),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Closed-form reference order (stride uses a multiply, not accumulation).
    function automatic int exp_addr(input int mode, input int step, input int j);
        int br;
        if (mode == 1) begin
            if (j == 0) return 0;
            br = 0;
            for (int i = 0; i < 8; i++)
                if (((j - 1) >> i) & 1) br |= 1 << (7 - i);
            return 1 + br;
        end
        if (mode == 2 && step > 0 && step < SIZE) return (j * step) % SIZE;
        return j;
    endfunction

    task automatic run_frames(input int nf, input int pct);
        int wf, wk, rf, rj, n, e, extra;
        logic hv, hl;
        logic [31:0] hd;
        wf = 0; wk = 0; rf = 0; rj = 0; n = 0; extra = 0;
        hv = 1'b0; hl = 1'b0; hd = '0;
        first_val = -1; last_acc = -1; last_out = -1; stall_seen = 0;
        while (rf < nf && n < 20000) begin
            @(negedge clk);
            n++;
            if (hv) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", out_data, hd);
                chk("stall_last", 32'(out_last), 32'(hl));
            end
            if (out_valid && first_val < 0) first_val = n;
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                e = f_base[rf] + exp_addr(f_mode[rf], f_step[rf], rj);
                chk("out_data", out_data, 32'(e));
                chk("out_last", 32'(out_last), 32'(rj == SIZE - 1));
                if (rf == 0) cap[rj] = int'(out_data) - f_base[0];
                last_out = n;
                rj++;
                if (rj == SIZE) begin
                    rj = 0;
                    rf++;
                end
            end
            hv = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
            if (wf < nf) begin
                in_valid = 1'b1;
                in_data  = 32'(f_base[wf] + wk);
                in_mode  = 2'(f_mode[wf]);
                in_step  = 9'(f_step[wf]);
                if (in_ready) begin
                    if (wk == SIZE - 1) last_acc = n;
                    wk++;
                    if (wk == SIZE) begin
                        wk = 0;
                        wf++;
                    end
                end else begin
                    stall_seen++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("frames_done", 32'(rf), 32'(nf));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("no_extra_beats", 32'(extra), 0);
    endtask

    task automatic write_frame(input int base, input int mode, input int step);
        int w;
        for (int k = 0; k < SIZE; k++) begin
            w = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 32'(base + k);
                in_mode  = 2'(mode);
                in_step  = 9'(step);
                w++;
            end while (!in_ready && w < 2000);
            if (!in_ready) begin
                chk("write_timeout", 32'(in_ready), 1);
                return;
            end
        end
    endtask

    task automatic perm_check();
        int ok;
        ok = 0;
        for (int j = 0; j < SIZE; j++) seen[j] = 0;
        for (int j = 0; j < SIZE; j++)
            if (cap[j] >= 0 && cap[j] < SIZE) seen[cap[j]]++;
        for (int j = 0; j < SIZE; j++) if (seen[j] == 1) ok++;
        chk("perm_once", 32'(ok), 32'(SIZE));
    endtask

    initial begin
        int got, n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_step = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);

        // natural order, latency and one-per-cycle burst
        f_mode[0] = 0; f_step[0] = 0; f_base[0] = 0;
        run_frames(1, 100);
        chk("latency", 32'(first_val - last_acc), 3);
        chk("burst_len", 32'(last_out - first_val), 32'(SIZE - 1));
        chk("m0_last_val", 32'(cap[256]), 256);

        // offset bit-reverse
        f_mode[0] = 1; f_step[0] = 0; f_base[0] = 0;
        run_frames(1, 100);
        chk("m1_j1", 32'(cap[1]), 1);
        chk("m1_j2", 32'(cap[2]), 129);
        chk("m1_j3", 32'(cap[3]), 65);
        chk("m1_j4", 32'(cap[4]), 193);
        chk("m1_j5", 32'(cap[5]), 33);
        chk("m1_j256", 32'(cap[256]), 256);
        perm_check();

        // stride 3
        f_mode[0] = 2; f_step[0] = 3; f_base[0] = 0;
        run_frames(1, 100);
        chk("m2_j1", 32'(cap[1]), 3);
        chk("m2_j85", 32'(cap[85]), 255);
        chk("m2_j86", 32'(cap[86]), 1);
        chk("m2_j87", 32'(cap[87]), 4);
        perm_check();
        chk("m2_cfg_err", 32'(cfg_err), 0);

        // two frames back to back with a free-running consumer
        f_mode[0] = 0; f_step[0] = 0; f_base[0] = 100000;
        f_mode[1] = 2; f_step[1] = 7; f_base[1] = 200000;
        run_frames(2, 100);
        chk("burst_2frames", 32'(last_out - first_val), 32'(2 * SIZE - 1));

        // three frames, random backpressure
        f_mode[0] = 0; f_step[0] = 0;   f_base[0] = 1000;
        f_mode[1] = 1; f_step[1] = 0;   f_base[1] = 2000;
        f_mode[2] = 2; f_step[2] = 5;   f_base[2] = 3000;
        run_frames(3, 50);
        chk("in_ready_low_seen", 32'(stall_seen > 0), 1);
        chk("pre_err_cfg", 32'(cfg_err), 0);

        // bad stride, then reserved mode: both natural order
        f_mode[0] = 2; f_step[0] = 0; f_base[0] = 4000;
        run_frames(1, 70);
        chk("err_step0", 32'(cfg_err), 1);
        f_mode[0] = 3; f_step[0] = 9; f_base[0] = 6000;
        run_frames(1, 70);
        chk("err_sticky", 32'(cfg_err), 1);

        // reset in the middle of a frame with another frame buffered
        out_ready = 1'b0;
        write_frame(0, 0, 0);
        write_frame(1000, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("both_full_in_ready", 32'(in_ready), 0);
        got = 0; n = 0;
        while (got < 100 && n < 2000) begin
            @(negedge clk);
            n++;
            out_ready = 1'b1;
            if (out_valid) begin
                chk("pre_rst_data", out_data, 32'(got));
                got++;
            end
        end
        chk("pre_rst_count", 32'(got), 100);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_cfg_err", 32'(cfg_err), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_quiet", 32'(out_valid), 0);
        f_mode[0] = 0; f_step[0] = 0; f_base[0] = 0;
        run_frames(1, 100);
        chk("post_rst_last", 32'(cap[256]), 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
